writeback_lsu: RTL
==================

# writeback_lsu

Parametrised successor to the single-cycle writeback stage. Sits between the memory stage and the register file, and holds a one-entry stage register. ALU results are written back one cycle after acceptance. Loads wait in a two-state FSM for the data-memory response, which is byte/word extracted and sign/zero-extended before writeback; the block stalls upstream meanwhile. Every op that completes also emits a retire pulse and increments a wrapping retired-instruction counter.

## Interface
Parameters:
- IALU_WORD_WIDTH, 16, result/register word width; also data-memory read width
- REG_IDX_WIDTH, 4, register index width
- PMEM_WORD_WIDTH, 16, instruction word width
- PC_WIDTH, 12, program counter width
- RET_CNT_WIDTH, 16, retired-instruction counter width
- ZERO_REG_HARDWIRED, 1, when 1, register writes to index 0 are suppressed

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- in_valid  in  1  upstream op present
- in_flush  in  1  synchronous kill of held/incoming op
- in_act_write_res_to_reg  in  1  op writes a register
- in_is_load  in  1  op is a load; in_res carries the byte address
- in_load_byte  in  1  load is a byte (else full word)
- in_load_signed  in  1  sign-extend byte load (else zero-extend)
- in_instr  in  PMEM_WORD_WIDTH  instruction word
- in_pc  in  PC_WIDTH  instruction PC
- in_res  in  IALU_WORD_WIDTH  ALU result or load address
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- dmem_rdata  in  IALU_WORD_WIDTH  load data
- dmem_rvalid  in  1  load data valid (one-cycle pulse)
- out_stall  out  1  upstream must hold its op
- out_act_write_res_to_reg  out  1  register-file write enable (one-cycle pulse)
- out_res  out  IALU_WORD_WIDTH  write data
- out_res_reg_idx  out  REG_IDX_WIDTH  write index
- out_retire_valid  out  1  op retired (one-cycle pulse)
- out_retire_pc  out  PC_WIDTH  PC of retired op
- out_retire_instr  out  PMEM_WORD_WIDTH  instruction of retired op
- out_retired_count  out  RET_CNT_WIDTH  retired ops, wraps at 2^RET_CNT_WIDTH
- out_err_spurious_rvalid  out  1  sticky: dmem_rvalid seen while not waiting

## Operation
- States: IDLE, LOAD_WAIT. out_stall = (state == LOAD_WAIT) && !in_flush. It is combinational.
- Accept: in_valid && !out_stall && !in_flush at an edge. Fields are captured into the hold registers.
- IDLE, accepted non-load:
  - next cycle, out_act = in_act_write_res_to_reg, with the write masked if ZERO_REG_HARDWIRED && idx==0.
  - out_res = in_res; out_res_reg_idx = idx.
  - out_retire_valid = 1; counter increments.
  - state stays IDLE.
- IDLE, accepted load:
  - state goes to LOAD_WAIT; no write or retire pulse that cycle.
- LOAD_WAIT, dmem_rvalid = 1:
  - next cycle, write outputs carry the extended data with the held act/idx (masking as above).
  - retire pulse with held pc/instr; counter increments.
  - state returns to IDLE.
  - No new op is accepted at this edge.
- LOAD_WAIT, no rvalid: all pulses stay 0 and the state holds.
- Load extraction:
  - word: data = dmem_rdata.
  - byte: byte = address[0] ? rdata[15:8] : rdata[7:0] (little-endian; for general widths, byte lane = address[0]).
  - signed: replicate bit 7 into the upper bits; unsigned: zero-fill.
- in_flush has priority over accept and rvalid in the same cycle:
  - the held op is dropped with no write, no retire and no count;
  - state goes to IDLE;
  - the incoming op is not accepted.
- dmem_rvalid in IDLE: ignored for data; sets out_err_spurious_rvalid, which is cleared only by reset.
- Pulse outputs are 0 in any cycle with no completion. out_res, out_res_reg_idx, out_retire_pc and out_retire_instr hold their last values.

## Timing
- Reset (reset = 0, asynchronous):
  - state goes to IDLE.
  - Every output register clears to 0: out_act, out_res, out_res_reg_idx, out_retire_*, out_retired_count, out_err_spurious_rvalid.
  - out_stall = 0.
  - A load pending at reset is discarded.
- Non-load latency: accepted at edge N; write and retire pulses are high during cycle N..N+1. Throughput is 1 per cycle.
- Load latency:
  - accepted at edge N; out_stall is high from after edge N.
  - dmem_rvalid is sampled at edge M ≥ N+1; the write/retire pulse is high during the cycle after M, and out_stall is low in that cycle.
  - Minimum spacing between back-to-back loads is 2 cycles.
- rvalid and flush in the same cycle: the flush wins and the load data is discarded.
- Counter: 2^RET_CNT_WIDTH−1 plus one retire gives 0.

## Test plan
- Reset then ALU op (pc=0x010, res=0x1234, idx=3, act=1) -> next cycle: out_act=1, out_res=0x1234, idx=3, retire_pc=0x010, count=1.
- Signed byte load, address=0x0001, rdata=0x80FF, rvalid 3 cycles later -> out_stall high for 3 cycles, then out_res=0xFF80; unsigned variant gives 0x0080; word variant gives 0x80FF.
- Write to idx 0 with act=1, ZERO_REG_HARDWIRED=1 -> out_act=0, retire_valid=1, count increments.
- Load waiting, then in_flush and dmem_rvalid in the same cycle -> no write, no retire, state IDLE, out_stall=0 in the next cycle.
- dmem_rvalid pulse in IDLE -> out_err_spurious_rvalid=1 and stays 1; a reset pulse clears it to 0.
- RET_CNT_WIDTH=4: 17 ALU ops back-to-back -> 17 consecutive retire pulses, final count=1; assert reset mid-load -> all outputs 0 immediately.

Source files
------------

// File: rtl/writeback_lsu.sv
// writeback_lsu: one-entry writeback stage with load-wait FSM, extension, retire pulse and counter
module writeback_lsu #(
  parameter int IALU_WORD_WIDTH    = 16,
  parameter int REG_IDX_WIDTH      = 4,
  parameter int PMEM_WORD_WIDTH    = 16,
  parameter int PC_WIDTH           = 12,
  parameter int RET_CNT_WIDTH      = 16,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_flush,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_is_load,
  input  logic                       in_load_byte,
  input  logic                       in_load_signed,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [IALU_WORD_WIDTH-1:0] dmem_rdata,
  input  logic                       dmem_rvalid,
  output logic                       out_stall,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic                       out_retire_valid,
  output logic [PC_WIDTH-1:0]        out_retire_pc,
  output logic [PMEM_WORD_WIDTH-1:0] out_retire_instr,
  output logic [RET_CNT_WIDTH-1:0]   out_retired_count,
  output logic                       out_err_spurious_rvalid
);
  localparam int W = IALU_WORD_WIDTH;
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t state_q, state_d;
  logic                       act_q, lane_q, byte_q, signed_q;
  logic [REG_IDX_WIDTH-1:0]   idx_q;
  logic [PC_WIDTH-1:0]        pc_q;
  logic [PMEM_WORD_WIDTH-1:0] instr_q;
  logic                       wb_act_q, ret_valid_q, err_q;
  logic [W-1:0]               wb_res_q;
  logic [REG_IDX_WIDTH-1:0]   wb_idx_q;
  logic [PC_WIDTH-1:0]        ret_pc_q;
  logic [PMEM_WORD_WIDTH-1:0] ret_instr_q;
  logic [RET_CNT_WIDTH-1:0]   cnt_q;
  logic                       accept, alu_done, load_done, done, wr_act, we;
  logic [REG_IDX_WIDTH-1:0]   wr_idx;
  logic [7:0]                 ld_byte;
  logic [W-1:0]               ld_data;
  assign accept    = in_valid && !out_stall && !in_flush;
  assign alu_done  = accept && !in_is_load;
  assign load_done = state_q == LOAD_WAIT && dmem_rvalid && !in_flush;
  assign done      = alu_done || load_done;
  assign wr_act    = alu_done ? in_act_write_res_to_reg : act_q;
  assign wr_idx    = alu_done ? in_res_reg_idx : idx_q;
  assign we        = done && wr_act && !(ZERO_REG_HARDWIRED != 0 && wr_idx == '0);
  assign ld_byte   = dmem_rdata[8*lane_q +: 8];
  assign ld_data   = !byte_q ? dmem_rdata :
                     signed_q ? {{(W-8){ld_byte[7]}}, ld_byte} : {{(W-8){1'b0}}, ld_byte};
  // state register; a load pending at reset is discarded by returning to IDLE
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  // next state: flush always returns to IDLE, accepted loads wait, load data ends the wait
  always_comb
    state_d = in_flush ? IDLE : (accept && in_is_load) ? LOAD_WAIT : load_done ? IDLE : state_q;
  // stall upstream only while waiting and not being flushed
  always_comb
    out_stall = state_q == LOAD_WAIT && !in_flush;
  // capture the op fields so a load can complete with its own act/idx/pc/instr
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {act_q, lane_q, byte_q, signed_q} <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (accept) begin
      {act_q, lane_q, byte_q, signed_q} <= {in_act_write_res_to_reg, in_res[0], in_load_byte, in_load_signed};
      idx_q   <= in_res_reg_idx;
      pc_q    <= in_pc;
      instr_q <= in_instr;
    end
  // registered writeback/retire outputs; data fields hold between completions
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wb_act_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      wb_res_q    <= '0;
      wb_idx_q    <= '0;
      ret_pc_q    <= '0;
      ret_instr_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_act_q    <= we;
      ret_valid_q <= done;
      cnt_q       <= cnt_q + RET_CNT_WIDTH'(done);
      err_q       <= err_q || (dmem_rvalid && state_q == IDLE);
      if (done) begin
        wb_res_q    <= alu_done ? in_res : ld_data;
        wb_idx_q    <= wr_idx;
        ret_pc_q    <= alu_done ? in_pc : pc_q;
        ret_instr_q <= alu_done ? in_instr : instr_q;
      end
    end
  assign out_act_write_res_to_reg = wb_act_q;
  assign out_res                  = wb_res_q;
  assign out_res_reg_idx          = wb_idx_q;
  assign out_retire_valid         = ret_valid_q;
  assign out_retire_pc            = ret_pc_q;
  assign out_retire_instr         = ret_instr_q;
  assign out_retired_count        = cnt_q;
  assign out_err_spurious_rvalid  = err_q;
endmodule
